// File: rtl/ldtu_rx_deframer.sv
// ldtu_rx_deframer
// Serial receiver and 32-bit word aligner for one LiTE-DTU output lane.
// Shifts in the serial stream (MSB first), hunts for the sync pattern,
// confirms it on LOCK_COUNT consecutive word boundaries, then delivers one
// aligned word every 32 clocks.
//
// Ports:
//   clock      serial bit clock, one bit per rising edge
//   rst_b      synchronous active-low reset
//   serial_in  serial data, first bit is the word MSB
//   pattern    32-bit sync word
//   train      high while the transmitter repeats pattern
//   word_out   last aligned word
//   word_valid one-cycle strobe when word_out updates
//   locked     high in LOCKED state
//   lock_lost  one-cycle pulse on LOCKED -> SEARCH
//   err_cnt    saturating mismatch count (locked and training)
//
// Build option: define LDTU_RX_ERRCNT_EN to implement err_cnt; otherwise
// err_cnt is tied to zero (lock/unlock behaviour is unchanged).
module ldtu_rx_deframer #(
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_MISSES = 3
) (
  input  logic        clock,
  input  logic        rst_b,
  input  logic        serial_in,
  input  logic [31:0] pattern,
  input  logic        train,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic        locked,
  output logic        lock_lost,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] MISS_N = 4'(UNLOCK_MISSES);

  state_t      state;
  logic [31:0] sr;
  logic [4:0]  bit_cnt;
  logic [3:0]  match_cnt;
  logic [3:0]  miss_cnt;
  logic [31:0] nxt;
  logic        hit;
  logic        boundary;

  // nxt is the word as it will look once this cycle's bit is shifted in
  assign nxt      = {sr[30:0], serial_in};
  assign hit      = (nxt == pattern);
  assign boundary = (bit_cnt == 5'd31);

  always_ff @(posedge clock) begin
    if (!rst_b) begin
      state      <= SEARCH;
      sr         <= '0;
      bit_cnt    <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      locked     <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      sr         <= nxt;
      bit_cnt    <= bit_cnt + 5'd1;
      word_valid <= 1'b0;
      lock_lost  <= 1'b0;
      case (state)
        SEARCH: begin
          // a match here defines the word boundary: restart the bit counter
          // so the next boundary lands exactly 32 bits later
          if (hit) begin
            bit_cnt   <= '0;
            match_cnt <= 4'd1;
            if (LOCK_N == 4'd1) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              state <= CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (boundary) begin
            if (hit) begin
              if (match_cnt + 4'd1 == LOCK_N) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + 4'd1;
              end
            end else begin
              state     <= SEARCH;
              match_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            // the word is delivered even when it is the one that drops lock
            word_out   <= nxt;
            word_valid <= 1'b1;
            if (train) begin
              if (!hit) begin
                if (miss_cnt + 4'd1 == MISS_N) begin
                  state     <= SEARCH;
                  locked    <= 1'b0;
                  lock_lost <= 1'b1;
                  miss_cnt  <= '0;
                end else begin
                  miss_cnt <= miss_cnt + 4'd1;
                end
              end else begin
                miss_cnt <= '0;
              end
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

`ifdef LDTU_RX_ERRCNT_EN
  logic miss_evt;
  assign miss_evt = (state == LOCKED) && boundary && train && !hit;

  always_ff @(posedge clock) begin
    if (!rst_b)
      err_cnt <= '0;
    else if (miss_evt && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_ldtu_rx_deframer.sv
// Directed bench for ldtu_rx_deframer: lock, data delivery, unlock on
// misses, tolerated sporadic misses, false-boundary rejection and reset.
module tb_ldtu_rx_deframer;

  localparam logic [31:0] PAT = 32'hA5A5F00F;
  localparam logic [31:0] BAD = 32'hA5A5F00E;
`ifdef LDTU_RX_ERRCNT_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic        clock = 1'b0;
  logic        rst_b = 1'b0;
  logic        serial_in = 1'b0;
  logic [31:0] pattern = PAT;
  logic        train = 1'b1;
  logic [31:0] word_out;
  logic        word_valid;
  logic        locked;
  logic        lock_lost;
  logic [7:0]  err_cnt;

  ldtu_rx_deframer #(.LOCK_COUNT(4), .UNLOCK_MISSES(3)) dut (
    .clock(clock), .rst_b(rst_b), .serial_in(serial_in), .pattern(pattern),
    .train(train), .word_out(word_out), .word_valid(word_valid),
    .locked(locked), .lock_lost(lock_lost), .err_cnt(err_cnt)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int tick = 0;
  int lock_tick = -1;
  logic prev_locked = 1'b0;
  logic [31:0] wq[$];
  int          wc[$];
  int   lost_n = 0;
  logic lost_valid = 1'b0;
  logic lost_locked = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // drive one bit, clock it in, then observe outputs 1ns after the edge
  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clock);
    #1;
    if (word_valid) begin
      wq.push_back(word_out);
      wc.push_back(tick);
    end
    if (locked && !prev_locked && lock_tick < 0) lock_tick = tick;
    prev_locked = locked;
    if (lock_lost) begin
      lost_n++;
      lost_valid  = word_valid;
      lost_locked = locked;
    end
    tick++;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic clr_log();
    wq.delete();
    wc.delete();
    lost_n = 0;
    lock_tick = -1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [12:0] ofs;
    int t0;
    // --- reset state
    rst_b = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    chk("rst_word", word_out, 32'h0);
    chk("rst_valid", 32'(word_valid), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_lost", 32'(lock_lost), 32'h0);
    chk("rst_err", 32'(err_cnt), 32'h0);
    rst_b = 1'b1;

    // --- 1: continuous pattern, lock and periodic strobes
    tick = 0; clr_log();
    for (int k = 0; k < 6; k++) send_word(PAT);
    chk("s1_lock_tick", 32'(lock_tick), 32'd127);
    chk("s1_nwords", 32'(wq.size()), 32'd2);
    chk("s1_word0", wq[0], PAT);
    chk("s1_word1", wq[1], PAT);
    chk("s1_first_strobe", 32'(wc[0]), 32'd159);
    chk("s1_period", 32'(wc[1] - wc[0]), 32'd32);

    // --- 2: training off, data words pass through
    clr_log(); train = 1'b0;
    send_word(32'h00000001);
    send_word(32'hDEADBEEF);
    chk("s2_nwords", 32'(wq.size()), 32'd2);
    chk("s2_word0", wq[0], 32'h00000001);
    chk("s2_word1", wq[1], 32'hDEADBEEF);
    chk("s2_err", 32'(err_cnt), 32'h0);
    chk("s2_locked", 32'(locked), 32'h1);

    // --- 3: three corrupted words drop lock, then relock
    clr_log(); train = 1'b1;
    send_word(PAT); send_word(PAT);
    send_word(BAD); send_word(BAD); send_word(BAD);
    chk("s3_nwords", 32'(wq.size()), 32'd5);
    chk("s3_last_word", wq[4], BAD);
    chk("s3_lost_n", 32'(lost_n), 32'd1);
    chk("s3_lost_valid", 32'(lost_valid), 32'h1);
    chk("s3_lost_locked", 32'(lost_locked), 32'h0);
    chk("s3_locked", 32'(locked), 32'h0);
    chk("s3_err", 32'(err_cnt), 32'(3 * ERR_EN));
    t0 = tick; lock_tick = -1;
    for (int k = 0; k < 3; k++) send_word(PAT);
    chk("s3_not_yet", 32'(locked), 32'h0);
    send_word(PAT);
    chk("s3_relock", 32'(locked), 32'h1);
    chk("s3_relock_tick", 32'(lock_tick - t0), 32'd127);

    // --- 4: two misses then one hit, repeated: lock must hold
    clr_log();
    for (int k = 0; k < 3; k++) begin
      send_word(BAD); send_word(BAD); send_word(PAT);
    end
    chk("s4_lost_n", 32'(lost_n), 32'd0);
    chk("s4_locked", 32'(locked), 32'h1);
    chk("s4_nwords", 32'(wq.size()), 32'd9);
    chk("s4_err", 32'(err_cnt), 32'(9 * ERR_EN));

    // --- 5: 13-bit offset, false match, 5 junk bits, then true stream
    rst_b = 1'b0; send_bit(1'b0); rst_b = 1'b1;
    tick = 0; clr_log(); prev_locked = 1'b0;
    ofs = 13'b1011001011001;
    for (int i = 12; i >= 0; i--) send_bit(ofs[i]);
    send_word(PAT);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    for (int k = 0; k < 6; k++) send_word(PAT);
    chk("s5_lock_tick", 32'(lock_tick), 32'd177);
    chk("s5_nwords", 32'(wq.size()), 32'd2);
    chk("s5_first_strobe", 32'(wc[0]), 32'd209);
    chk("s5_word0", wq[0], PAT);

    // --- 6: one-cycle reset mid-word while locked
    for (int i = 31; i >= 22; i--) send_bit(PAT[i]);
    rst_b = 1'b0; send_bit(PAT[21]); rst_b = 1'b1;
    chk("s6_word", word_out, 32'h0);
    chk("s6_valid", 32'(word_valid), 32'h0);
    chk("s6_locked", 32'(locked), 32'h0);
    chk("s6_lost", 32'(lock_lost), 32'h0);
    chk("s6_err", 32'(err_cnt), 32'h0);
    tick = 0; clr_log(); prev_locked = 1'b0;
    for (int k = 0; k < 5; k++) send_word(PAT);
    chk("s6_lock_tick", 32'(lock_tick), 32'd127);
    chk("s6_first_strobe", 32'(wc.size() > 0 ? wc[0] : -1), 32'd159);
    chk("s6_word0", wq.size() > 0 ? wq[0] : 32'h0, PAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
